// File: rtl/univ_shift_reg_if.sv
// Port bundle for univ_shift_reg. The optional rot input exists only when
// UNIV_SHIFT_REG_ROTATE_EN is defined.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   // No handshake: inputs are sampled on every rising clk edge where en=1;
   // outputs q/ser_out/cnt are registered and drained is decoded from cnt.
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] d;
   logic             ser_in_msb;
   logic             ser_in_lsb;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   logic             rot;
`endif
   logic [WIDTH-1:0] q;
   logic             ser_out;
   logic [CW-1:0]    cnt;
   logic             drained;

   modport master (
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      output rot,
`endif
      output en, mode, d, ser_in_msb, ser_in_lsb,
      input  q, ser_out, cnt, drained
   );

   modport slave (
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      input  rot,
`endif
      input  en, mode, d, ser_in_msb, ser_in_lsb,
      output q, ser_out, cnt, drained
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// registered serial output and saturating shift counter. Rotate option: UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   univ_shift_reg_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic             ser_out_q, ser_out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rot_sel;
   logic [CW-1:0]    cnt_inc;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   assign rot_sel = bus.rot;
`else
   assign rot_sel = 1'b0;
`endif

   // Counter stops at WIDTH; shifting itself carries on regardless.
   assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);

   always_comb begin
      q_d       = q_q;
      ser_out_d = ser_out_q;
      cnt_d     = cnt_q;
      if (bus.en) begin
         case (bus.mode)
            MODE_RIGHT: begin
               q_d       = {(rot_sel ? q_q[0] : bus.ser_in_msb), q_q[WIDTH-1:1]};
               ser_out_d = q_q[0];
               cnt_d     = cnt_inc;
            end
            MODE_LEFT: begin
               q_d       = {q_q[WIDTH-2:0], (rot_sel ? q_q[WIDTH-1] : bus.ser_in_lsb)};
               ser_out_d = q_q[WIDTH-1];
               cnt_d     = cnt_inc;
            end
            MODE_LOAD: begin
               q_d   = bus.d;
               cnt_d = '0;
            end
            MODE_HOLD: ;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q       <= RESET_VAL;
         ser_out_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         q_q       <= q_d;
         ser_out_q <= ser_out_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.q       = q_q;
   assign bus.ser_out = ser_out_q;
   assign bus.cnt     = cnt_q;
   assign bus.drained = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: directed cases plus random traffic checked
// against a bit-queue model of the register.
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int EW    = WIDTH + 1 + CW + 1;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic clk;
  logic reset;

  univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  // reference model: register as a queue of bits, index 0 = lsb
  bit m_bits[$];
  bit m_ser;
  int m_cnt;

  function automatic logic [EW-1:0] model_pack();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = m_bits[i];
    return {v, m_ser, CW'(m_cnt), (m_cnt == WIDTH)};
  endfunction

  task automatic model_load(input logic [WIDTH-1:0] v);
    m_bits.delete();
    for (int i = 0; i < WIDTH; i++) m_bits.push_back(v[i]);
  endtask

  task automatic cycle(input logic rst, input logic e, input logic [1:0] md,
                       input logic [WIDTH-1:0] dv, input logic smsb, input logic slsb,
                       input logic rt, input string nm);
    bit out_bit;
    bit rot_eff;
    @(negedge clk);
    reset          = rst;
    bus.en         = e;
    bus.mode       = md;
    bus.d          = dv;
    bus.ser_in_msb = smsb;
    bus.ser_in_lsb = slsb;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    bus.rot        = rt;
    rot_eff        = rt;
`else
    rot_eff        = 1'b0;
`endif
    if (rst) begin
      model_load(RESET_VAL);
      m_ser = 0;
      m_cnt = 0;
    end else if (e) begin
      if (md == 2'b01) begin
        out_bit = m_bits.pop_front();
        m_bits.push_back(rot_eff ? out_bit : smsb);
        m_ser = out_bit;
        m_cnt = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
      end else if (md == 2'b10) begin
        out_bit = m_bits.pop_back();
        m_bits.push_front(rot_eff ? out_bit : slsb);
        m_ser = out_bit;
        m_cnt = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
      end else if (md == 2'b11) begin
        model_load(dv);
        m_cnt = 0;
      end
    end
    exp_q.push_back(model_pack());
    name_q.push_back(nm);
  endtask

  // monitor: after every edge, compare DUT outputs with the oldest expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v;
      logic [EW-1:0] act_v;
      string         nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.q, bus.ser_out, bus.cnt, bus.drained};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got q=%h ser_out=%b cnt=%0d drained=%b, expected q=%h ser_out=%b cnt=%0d drained=%b",
                 nm, act_v[EW-1 -: WIDTH], act_v[CW+1], act_v[CW:1], act_v[0],
                 exp_v[EW-1 -: WIDTH], exp_v[CW+1], exp_v[CW:1], exp_v[0]);
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.mode = 2'b00;
    bus.d = '0;
    bus.ser_in_msb = 1'b0;
    bus.ser_in_lsb = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    bus.rot = 1'b0;
`endif
    model_load(RESET_VAL);
    m_ser = 0;
    m_cnt = 0;

    // reset beats a simultaneous load
    cycle(1, 1, 2'b11, 8'hA5, 0, 0, 0, "reset_over_load");
    // right shift after load
    cycle(0, 1, 2'b11, 8'hA5, 0, 0, 0, "load_a5");
    cycle(0, 1, 2'b01, 8'h00, 1, 0, 0, "shr_a5");
    // left shift after load
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0, "load_81");
    cycle(0, 1, 2'b10, 8'h00, 0, 0, 0, "shl_81");
    // saturation and drained, then load clears
    cycle(0, 1, 2'b11, 8'h3C, 0, 0, 0, "load_3c");
    for (int i = 0; i < 10; i++) cycle(0, 1, 2'b01, 8'h00, i[0], 0, 0, "shr_sat");
    cycle(0, 1, 2'b10, 8'h00, 0, 1, 0, "shl_while_drained");
    cycle(0, 1, 2'b11, 8'h5A, 0, 0, 0, "load_after_drain");
    // direction change keeps counting
    cycle(0, 1, 2'b01, 8'h00, 1, 0, 0, "dir_r");
    cycle(0, 1, 2'b10, 8'h00, 0, 1, 0, "dir_l");
    cycle(0, 1, 2'b00, 8'hFF, 1, 1, 0, "hold_mode");
    // enable low ignores load
    for (int i = 0; i < 3; i++) cycle(0, 0, 2'b11, 8'hFF, 1, 1, 0, "en_low");
    // reset mid-sequence, then resume
    cycle(0, 1, 2'b01, 8'h00, 1, 0, 0, "pre_reset_shift");
    cycle(1, 1, 2'b01, 8'h00, 1, 0, 0, "reset_mid_shift");
    cycle(0, 1, 2'b01, 8'h00, 1, 0, 0, "post_reset_shift");
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0, "rot_load");
    cycle(0, 1, 2'b01, 8'h00, 0, 0, 1, "rot_right");
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0, "rot_load2");
    cycle(0, 1, 2'b01, 8'h00, 0, 0, 0, "norot_right");
    cycle(0, 1, 2'b11, 8'h81, 0, 0, 0, "rot_load3");
    cycle(0, 1, 2'b10, 8'h00, 0, 0, 1, "rot_left");
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)), WIDTH'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), "random");
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
